// File: rtl/ex_csa_accum.sv
// ex_csa_accum: carry-save accumulator for 16-bit 3:2 compressor (P, Q) pairs.
// Each accepted pair is folded into a redundant sum/carry register with no
// carry propagation. On request, the running value is resolved by a split
// carry-propagate adder: the low 16 bits in one cycle and the upper
// ACC_BITS-16 bits in the next cycle.
// Optional feature macro: EX_CSA_ACC_CNT_EN builds a saturating 8-bit
// operand counter on outCount. Without it, outCount is tied to zero.
module ex_csa_accum #(
  parameter int unsigned ACC_BITS = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inValid,
  input  logic [15:0]         inP,
  input  logic [15:0]         inQ,
  input  logic                inReq,
  input  logic                inClear,
  output logic                inReady,
  output logic                outValid,
  output logic [ACC_BITS-1:0] outSum,
  output logic [7:0]          outCount
);

  localparam int unsigned HI_BITS = ACC_BITS - 16;

  typedef enum logic [1:0] {ACC, RES_LO, RES_HI, DONE} stateT;

  stateT state, nextState;

  logic [ACC_BITS-1:0] regS, regC;
  logic [ACC_BITS-1:0] carryVec, pExt, qVec, s1, c1, s2, c2;
  logic [15:0]         loSum;
  logic                loCarry;
  logic [16:0]         loAdd;
  logic [HI_BITS-1:0]  hiAdd;

  // 4:2 compression of {regS, regC<<1, P, Q<<1} through two 3:2 levels.
  // regC holds carries at weight 2^(i+1), so the level-2 carry is stored unshifted.
  always_comb begin
    carryVec = regC << 1;
    pExt     = ACC_BITS'(inP);
    qVec     = ACC_BITS'(inQ) << 1;
    s1       = regS ^ carryVec ^ pExt;
    c1       = ((regS & carryVec) | (regS & pExt) | (carryVec & pExt)) << 1;
    s2       = s1 ^ c1 ^ qVec;
    c2       = (s1 & c1) | (s1 & qVec) | (c1 & qVec);
  end

  // Split carry-propagate adder halves for the two resolve cycles.
  always_comb begin
    loAdd = {1'b0, regS[15:0]} + {1'b0, carryVec[15:0]};
    hiAdd = regS[ACC_BITS-1:16] + carryVec[ACC_BITS-1:16] + HI_BITS'(loCarry);
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ACC;
    else       state <= nextState;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    nextState = state;
    inReady   = 1'b0;
    outValid  = 1'b0;
    case (state)
      ACC: begin
        inReady = 1'b1;
        if (inReq) nextState = RES_LO;
      end
      RES_LO: nextState = RES_HI;
      RES_HI: nextState = DONE;
      DONE: begin
        inReady   = 1'b1;
        outValid  = 1'b1;
        nextState = inReq ? RES_LO : ACC;
      end
      default: nextState = ACC;
    endcase
    if (inClear) nextState = ACC;
  end

  // Redundant accumulator, low-half latch, and resolved result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regS    <= '0;
      regC    <= '0;
      outSum  <= '0;
      loSum   <= '0;
      loCarry <= 1'b0;
    end else if (inClear) begin
      regS    <= '0;
      regC    <= '0;
      outSum  <= '0;
      loSum   <= '0;
      loCarry <= 1'b0;
    end else begin
      case (state)
        ACC, DONE: begin
          if (inValid) begin
            regS <= s2;
            regC <= c2;
          end
        end
        RES_LO: begin
          loSum   <= loAdd[15:0];
          loCarry <= loAdd[16];
        end
        RES_HI: begin
          // The resolved value re-enters the accumulator as a plain sum,
          // so accumulation continues from it with an empty carry vector.
          outSum <= {hiAdd, loSum};
          regS   <= {hiAdd, loSum};
          regC   <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef EX_CSA_ACC_CNT_EN
  logic [7:0] count;

  // Saturating count of accepted pairs since the last clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                       count <= '0;
    else if (inClear)                                count <= '0;
    else if (inReady && inValid && (count != 8'hFF)) count <= count + 8'd1;
  end

  assign outCount = count;
`else
  assign outCount = '0;
`endif

endmodule

// File: tb/tb_ex_csa_accum.sv
// Self-checking bench for ex_csa_accum (ACC_BITS=32). The reference model
// keeps the accumulated value as a plain integer sum of P + 2*Q, modulo 2^32,
// and tracks the resolve timing as a count of busy cycles after a request.
module tb_ex_csa_accum;
  logic        clock = 1'b0;
  logic        reset;
  logic        inValid, inReq, inClear;
  logic [15:0] inP, inQ;
  logic        inReady, outValid;
  logic [31:0] outSum;
  logic [7:0]  outCount;

  int errors = 0;
  int checks = 0;

  logic [31:0] mAcc, mOut;
  int          mCnt, mBusy;
  bit          mValid;

  ex_csa_accum #(.ACC_BITS(32)) dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inP(inP), .inQ(inQ),
    .inReq(inReq), .inClear(inClear), .inReady(inReady), .outValid(outValid),
    .outSum(outSum), .outCount(outCount)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] expCount();
`ifdef EX_CSA_ACC_CNT_EN
    return 8'(mCnt);
`else
    return 8'h00;
`endif
  endfunction

  task automatic modelZero();
    mAcc = '0; mOut = '0; mCnt = 0; mBusy = 0; mValid = 0;
  endtask

  // Drive one cycle of inputs, apply the rules to the model at the edge, and
  // return 1 time unit after the edge.
  task automatic step(input bit v, input logic [15:0] p, input logic [15:0] q,
                      input bit r, input bit c);
    inValid = v; inP = p; inQ = q; inReq = r; inClear = c;
    @(posedge clock);
    mValid = 0;
    if (c) begin
      modelZero();
    end else if (mBusy == 0) begin
      if (v) begin
        mAcc = mAcc + 32'(p) + (32'(q) << 1);
        if (mCnt < 255) mCnt++;
      end
      if (r) mBusy = 2;
    end else begin
      mBusy--;
      if (mBusy == 0) begin
        mOut   = mAcc;
        mValid = 1;
      end
    end
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    inValid = 0; inP = '0; inQ = '0; inReq = 0; inClear = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    modelZero();
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid got %b exp 0", outValid); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady got %b exp 1", inReady); end
    checks++; if (outSum !== 32'h0) begin errors++; $display("FAIL reset_outSum got %h exp 00000000", outSum); end
    checks++; if (outCount !== 8'h00) begin errors++; $display("FAIL reset_outCount got %h exp 00", outCount); end
  endtask

  task automatic test_basic();
    step(1, 16'h0003, 16'h0001, 0, 0);
    step(0, 16'h0, 16'h0, 1, 0);
    checks++; if (inReady !== 1'b0 || outValid !== 1'b0) begin errors++; $display("FAIL basic_n1 got rdy=%b vld=%b exp rdy=0 vld=0", inReady, outValid); end
    step(0, 16'h0, 16'h0, 0, 0);
    checks++; if (inReady !== 1'b0 || outValid !== 1'b0) begin errors++; $display("FAIL basic_n2 got rdy=%b vld=%b exp rdy=0 vld=0", inReady, outValid); end
    step(0, 16'h0, 16'h0, 0, 0);
    checks++; if (outValid !== 1'b1 || inReady !== 1'b1) begin errors++; $display("FAIL basic_n3 got rdy=%b vld=%b exp rdy=1 vld=1", inReady, outValid); end
    checks++; if (outSum !== 32'h00000005) begin errors++; $display("FAIL basic_sum got %h exp 00000005", outSum); end
    step(0, 16'h0, 16'h0, 0, 0);
    checks++; if (outValid !== 1'b0 || outSum !== 32'h00000005) begin errors++; $display("FAIL basic_hold got vld=%b sum=%h exp vld=0 sum=00000005", outValid, outSum); end
  endtask

  task automatic test_multi();
    step(0, 16'h0, 16'h0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 16'hFFFF, 16'h8000, (i == 3), 0);
    repeat (2) step(0, 16'h0, 16'h0, 0, 0);
    checks++; if (outValid !== 1'b1 || outSum !== 32'h0007FFFC) begin errors++; $display("FAIL multi_sum got vld=%b sum=%h exp vld=1 sum=0007FFFC", outValid, outSum); end
`ifdef EX_CSA_ACC_CNT_EN
    checks++; if (outCount !== 8'd4) begin errors++; $display("FAIL multi_count got %0d exp 4", outCount); end
`else
    checks++; if (outCount !== 8'd0) begin errors++; $display("FAIL multi_count got %0d exp 0", outCount); end
`endif
  endtask

  // Continues from test_multi's accumulated 0x0007FFFC.
  task automatic test_ignored();
    step(0, 16'h0, 16'h0, 1, 0);
    step(1, 16'h1234, 16'h0001, 0, 0);
    step(1, 16'h0005, 16'h0005, 1, 0);
    checks++; if (outValid !== 1'b1 || outSum !== 32'h0007FFFC) begin errors++; $display("FAIL ignored_sum got vld=%b sum=%h exp vld=1 sum=0007FFFC", outValid, outSum); end
    step(0, 16'h0, 16'h0, 1, 0);
    repeat (2) step(0, 16'h0, 16'h0, 0, 0);
    checks++; if (outValid !== 1'b1 || outSum !== 32'h0007FFFC) begin errors++; $display("FAIL reresolve_sum got vld=%b sum=%h exp vld=1 sum=0007FFFC", outValid, outSum); end
    step(1, 16'h0001, 16'h0000, 1, 0);
    repeat (2) step(0, 16'h0, 16'h0, 0, 0);
    checks++; if (outValid !== 1'b1 || outSum !== 32'h0007FFFD) begin errors++; $display("FAIL postresolve_add got vld=%b sum=%h exp vld=1 sum=0007FFFD", outValid, outSum); end
    checks++; if (outCount !== expCount()) begin errors++; $display("FAIL resolve_count got %0d exp %0d", outCount, expCount()); end
  endtask

  task automatic test_wrap();
    longint rem;
    logic [15:0] q16, p16;
    step(0, 16'h0, 16'h0, 0, 1);
    rem = 64'h00000000FFFFFFFF;
    while (rem >= 64'h2FFFD) begin
      step(1, 16'hFFFF, 16'hFFFF, 0, 0);
      rem -= 64'h2FFFD;
    end
    q16 = (rem >= 64'h1FFFE) ? 16'hFFFF : 16'(rem >> 1);
    p16 = 16'(rem - 2 * longint'(q16));
    step(1, p16, q16, 1, 0);
    repeat (2) step(0, 16'h0, 16'h0, 0, 0);
    checks++; if (outValid !== 1'b1 || outSum !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_full got vld=%b sum=%h exp vld=1 sum=FFFFFFFF", outValid, outSum); end
    step(1, 16'h0001, 16'h0000, 1, 0);
    repeat (2) step(0, 16'h0, 16'h0, 0, 0);
    checks++; if (outValid !== 1'b1 || outSum !== 32'h00000000) begin errors++; $display("FAIL wrap_zero got vld=%b sum=%h exp vld=1 sum=00000000", outValid, outSum); end
    step(0, 16'h0, 16'h0, 0, 1);
    step(1, 16'hFFFF, 16'h0000, 0, 0);
    step(1, 16'h0001, 16'h0000, 1, 0);
    repeat (2) step(0, 16'h0, 16'h0, 0, 0);
    checks++; if (outValid !== 1'b1 || outSum !== 32'h00010000) begin errors++; $display("FAIL locarry_ripple got vld=%b sum=%h exp vld=1 sum=00010000", outValid, outSum); end
  endtask

  task automatic test_clear_reshi();
    step(0, 16'h0, 16'h0, 0, 1);
    step(1, 16'h0007, 16'h0000, 1, 0);
    step(0, 16'h0, 16'h0, 0, 0);
    step(1, 16'h0009, 16'h0009, 0, 1);
    checks++; if (outValid !== 1'b0 || inReady !== 1'b1 || outSum !== 32'h0) begin errors++; $display("FAIL clear_reshi got vld=%b rdy=%b sum=%h exp vld=0 rdy=1 sum=00000000", outValid, inReady, outSum); end
    step(1, 16'h0002, 16'h0000, 1, 0);
    step(0, 16'h0, 16'h0, 0, 0);
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL clear_early_valid got %b exp 0", outValid); end
    step(0, 16'h0, 16'h0, 0, 0);
    checks++; if (outValid !== 1'b1 || outSum !== 32'h00000002) begin errors++; $display("FAIL clear_next_sum got vld=%b sum=%h exp vld=1 sum=00000002", outValid, outSum); end
`ifdef EX_CSA_ACC_CNT_EN
    checks++; if (outCount !== 8'd1) begin errors++; $display("FAIL clear_count got %0d exp 1", outCount); end
`else
    checks++; if (outCount !== 8'd0) begin errors++; $display("FAIL clear_count got %0d exp 0", outCount); end
`endif
  endtask

  task automatic test_saturate();
    step(0, 16'h0, 16'h0, 0, 1);
    for (int i = 0; i < 300; i++) step(1, 16'h0001, 16'h0000, 0, 0);
`ifdef EX_CSA_ACC_CNT_EN
    checks++; if (outCount !== 8'd255) begin errors++; $display("FAIL sat_count got %0d exp 255", outCount); end
`else
    checks++; if (outCount !== 8'd0) begin errors++; $display("FAIL sat_count got %0d exp 0", outCount); end
`endif
  endtask

  task automatic test_random();
    bit v, r, c;
    step(0, 16'h0, 16'h0, 0, 1);
    for (int i = 0; i < 500; i++) begin
      v = ($urandom_range(3) != 0);
      r = ($urandom_range(7) == 0);
      c = ($urandom_range(63) == 0);
      step(v, 16'($urandom), 16'($urandom), r, c);
      checks++;
      if (outValid !== mValid || inReady !== (mBusy == 0) || outSum !== mOut || outCount !== expCount()) begin
        errors++;
        $display("FAIL random_cycle%0d got vld=%b rdy=%b sum=%h cnt=%0d exp vld=%b rdy=%b sum=%h cnt=%0d",
                 i, outValid, inReady, outSum, outCount, mValid, (mBusy == 0), mOut, expCount());
      end
    end
  endtask

  task automatic test_async_reset();
    step(0, 16'h0, 16'h0, 0, 1);
    step(1, 16'h0003, 16'h0000, 1, 0);
    repeat (2) step(0, 16'h0, 16'h0, 0, 0);
    checks++; if (outValid !== 1'b1 || outSum !== 32'h00000003) begin errors++; $display("FAIL async_pre got vld=%b sum=%h exp vld=1 sum=00000003", outValid, outSum); end
    #1 reset = 1'b1;
    #1;
    checks++; if (outValid !== 1'b0 || outSum !== 32'h0 || inReady !== 1'b1 || outCount !== 8'h0) begin errors++; $display("FAIL async_reset got vld=%b sum=%h rdy=%b cnt=%0d exp vld=0 sum=00000000 rdy=1 cnt=0", outValid, outSum, inReady, outCount); end
    #1 reset = 1'b0;
    modelZero();
    step(0, 16'h0, 16'h0, 0, 0);
    checks++; if (outValid !== 1'b0 || outSum !== 32'h0) begin errors++; $display("FAIL async_post got vld=%b sum=%h exp vld=0 sum=00000000", outValid, outSum); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi();
    test_ignored();
    test_wrap();
    test_clear_reshi();
    test_saturate();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
